// File: rtl/sha2_kconst_seq_if.sv
// Handshake bundle between the hash control FSM (master) and the round-constant
// sequencer (slave).
interface sha2_kconst_seq_if;
    logic        start;
    logic        mode;
    logic        stall;
    logic        abort;
    logic        busy;
    logic        k_valid;
    logic [63:0] k_out;
    logic [6:0]  round_idx;
    logic        k_last;
    logic        done;

    modport master (
        output start, mode, stall, abort,
        input  busy, k_valid, k_out, round_idx, k_last, done
    );

    modport slave (
        input  start, mode, stall, abort,
        output busy, k_valid, k_out, round_idx, k_last, done
    );
endinterface

// File: rtl/sha2_kconst_seq.sv
// SHA-2 round-constant sequencer: streams K[0..N-1] (N=80 SHA-512, N=64 SHA-256)
// one per cycle through a 1- or 2-stage output pipeline with stall and abort.
module sha2_kconst_seq #(
    parameter int PIPE_STAGES = 1,
    parameter bit EN_SHA256   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    sha2_kconst_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [6:0]  cnt, cnt_nxt;
    logic        mode_q, mode_nxt;
    logic        done_q, done_nxt;
    logic        issue;
    logic [6:0]  last_idx;
    logic [63:0] k_full;
    logic [63:0] k_sel;

    logic        st_valid [PIPE_STAGES];
    logic        st_last  [PIPE_STAGES];
    logic [6:0]  st_idx   [PIPE_STAGES];
    logic [63:0] st_k     [PIPE_STAGES];

    logic        out_valid;
    logic        out_last;

    // FIPS 180-4 SHA-512 constants; SHA-256 reuses the upper halves of the first 64.
    function automatic logic [63:0] k512(input logic [6:0] idx);
        logic [63:0] k;
        case (idx)
            7'd0:  k = 64'h428a2f98d728ae22;
            7'd1:  k = 64'h7137449123ef65cd;
            7'd2:  k = 64'hb5c0fbcfec4d3b2f;
            7'd3:  k = 64'he9b5dba58189dbbc;
            7'd4:  k = 64'h3956c25bf348b538;
            7'd5:  k = 64'h59f111f1b605d019;
            7'd6:  k = 64'h923f82a4af194f9b;
            7'd7:  k = 64'hab1c5ed5da6d8118;
            7'd8:  k = 64'hd807aa98a3030242;
            7'd9:  k = 64'h12835b0145706fbe;
            7'd10: k = 64'h243185be4ee4b28c;
            7'd11: k = 64'h550c7dc3d5ffb4e2;
            7'd12: k = 64'h72be5d74f27b896f;
            7'd13: k = 64'h80deb1fe3b1696b1;
            7'd14: k = 64'h9bdc06a725c71235;
            7'd15: k = 64'hc19bf174cf692694;
            7'd16: k = 64'he49b69c19ef14ad2;
            7'd17: k = 64'hefbe4786384f25e3;
            7'd18: k = 64'h0fc19dc68b8cd5b5;
            7'd19: k = 64'h240ca1cc77ac9c65;
            7'd20: k = 64'h2de92c6f592b0275;
            7'd21: k = 64'h4a7484aa6ea6e483;
            7'd22: k = 64'h5cb0a9dcbd41fbd4;
            7'd23: k = 64'h76f988da831153b5;
            7'd24: k = 64'h983e5152ee66dfab;
            7'd25: k = 64'ha831c66d2db43210;
            7'd26: k = 64'hb00327c898fb213f;
            7'd27: k = 64'hbf597fc7beef0ee4;
            7'd28: k = 64'hc6e00bf33da88fc2;
            7'd29: k = 64'hd5a79147930aa725;
            7'd30: k = 64'h06ca6351e003826f;
            7'd31: k = 64'h142929670a0e6e70;
            7'd32: k = 64'h27b70a8546d22ffc;
            7'd33: k = 64'h2e1b21385c26c926;
            7'd34: k = 64'h4d2c6dfc5ac42aed;
            7'd35: k = 64'h53380d139d95b3df;
            7'd36: k = 64'h650a73548baf63de;
            7'd37: k = 64'h766a0abb3c77b2a8;
            7'd38: k = 64'h81c2c92e47edaee6;
            7'd39: k = 64'h92722c851482353b;
            7'd40: k = 64'ha2bfe8a14cf10364;
            7'd41: k = 64'ha81a664bbc423001;
            7'd42: k = 64'hc24b8b70d0f89791;
            7'd43: k = 64'hc76c51a30654be30;
            7'd44: k = 64'hd192e819d6ef5218;
            7'd45: k = 64'hd69906245565a910;
            7'd46: k = 64'hf40e35855771202a;
            7'd47: k = 64'h106aa07032bbd1b8;
            7'd48: k = 64'h19a4c116b8d2d0c8;
            7'd49: k = 64'h1e376c085141ab53;
            7'd50: k = 64'h2748774cdf8eeb99;
            7'd51: k = 64'h34b0bcb5e19b48a8;
            7'd52: k = 64'h391c0cb3c5c95a63;
            7'd53: k = 64'h4ed8aa4ae3418acb;
            7'd54: k = 64'h5b9cca4f7763e373;
            7'd55: k = 64'h682e6ff3d6b2b8a3;
            7'd56: k = 64'h748f82ee5defb2fc;
            7'd57: k = 64'h78a5636f43172f60;
            7'd58: k = 64'h84c87814a1f0ab72;
            7'd59: k = 64'h8cc702081a6439ec;
            7'd60: k = 64'h90befffa23631e28;
            7'd61: k = 64'ha4506cebde82bde9;
            7'd62: k = 64'hbef9a3f7b2c67915;
            7'd63: k = 64'hc67178f2e372532b;
            7'd64: k = 64'hca273eceea26619c;
            7'd65: k = 64'hd186b8c721c0c207;
            7'd66: k = 64'heada7dd6cde0eb1e;
            7'd67: k = 64'hf57d4f7fee6ed178;
            7'd68: k = 64'h06f067aa72176fba;
            7'd69: k = 64'h0a637dc5a2c898a6;
            7'd70: k = 64'h113f9804bef90dae;
            7'd71: k = 64'h1b710b35131c471b;
            7'd72: k = 64'h28db77f523047d84;
            7'd73: k = 64'h32caab7b40c72493;
            7'd74: k = 64'h3c9ebe0a15c9bebc;
            7'd75: k = 64'h431d67c49c100d4c;
            7'd76: k = 64'h4cc5d4becb3e42b6;
            7'd77: k = 64'h597f299cfc657e2a;
            7'd78: k = 64'h5fcb6fab3ad6faec;
            7'd79: k = 64'h6c44198c4a475817;
            default: k = 64'h0;
        endcase
        return k;
    endfunction

    assign last_idx  = mode_q ? 7'd63 : 7'd79;
    assign k_full    = k512(cnt);
    assign k_sel     = mode_q ? {32'h0, k_full[63:32]} : k_full;
    assign out_valid = st_valid[PIPE_STAGES-1];
    assign out_last  = st_last[PIPE_STAGES-1];

    // Abort beats stall and start; stall freezes everything else, including start acceptance.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mode_nxt  = mode_q;
        done_nxt  = 1'b0;
        issue     = 1'b0;
        if (bus.abort) begin
            state_nxt = IDLE;
            cnt_nxt   = 7'd0;
        end else if (!bus.stall) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mode_nxt  = EN_SHA256 ? bus.mode : 1'b0;
                        cnt_nxt   = 7'd0;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    issue = 1'b1;
                    if (cnt == last_idx) begin
                        cnt_nxt   = 7'd0;
                        state_nxt = DRAIN;
                    end else begin
                        cnt_nxt = cnt + 7'd1;
                    end
                end
                DRAIN: begin
                    if (out_valid && out_last) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 7'd0;
            mode_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            mode_q <= mode_nxt;
            done_q <= done_nxt;
        end
    end

    // Index and last flag ride alongside the constant so they stay aligned at any depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                st_valid[i] <= 1'b0;
                st_last[i]  <= 1'b0;
                st_idx[i]   <= 7'd0;
                st_k[i]     <= 64'h0;
            end
        end else if (bus.abort) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                st_valid[i] <= 1'b0;
                st_last[i]  <= 1'b0;
                st_idx[i]   <= 7'd0;
                st_k[i]     <= 64'h0;
            end
        end else if (!bus.stall) begin
            st_valid[0] <= issue;
            st_last[0]  <= issue && (cnt == last_idx);
            st_idx[0]   <= issue ? cnt : 7'd0;
            st_k[0]     <= issue ? k_sel : 64'h0;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_last[i]  <= st_last[i-1];
                st_idx[i]   <= st_idx[i-1];
                st_k[i]     <= st_k[i-1];
            end
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.k_valid   = out_valid;
    assign bus.k_last    = out_last;
    assign bus.round_idx = st_idx[PIPE_STAGES-1];
    assign bus.k_out     = st_k[PIPE_STAGES-1];
    assign bus.done      = done_q;
endmodule

// File: tb/tb_sha2_kconst_seq.sv
// Self-checking bench for sha2_kconst_seq: a 1-stage and a 2-stage instance share
// stimulus and are each checked against a round-stream model built from FIPS 180-4 K.
module tb_sha2_kconst_seq;
    logic clk = 1'b0;
    logic rst_n;
    logic start, mode, stall, abort;
    int   checks = 0;
    int   passes = 0;

    logic [63:0] k_tab [80];

    logic        o_busy  [2];
    logic        o_valid [2];
    logic        o_last  [2];
    logic        o_done  [2];
    logic [63:0] o_k     [2];
    logic [6:0]  o_idx   [2];

    always #5 clk = ~clk;

    sha2_kconst_seq_if bus1 ();
    sha2_kconst_seq_if bus2 ();

    assign bus1.start = start;
    assign bus1.mode  = mode;
    assign bus1.stall = stall;
    assign bus1.abort = abort;
    assign bus2.start = start;
    assign bus2.mode  = mode;
    assign bus2.stall = stall;
    assign bus2.abort = abort;

    sha2_kconst_seq #(.PIPE_STAGES(1), .EN_SHA256(1'b1)) u_p1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    sha2_kconst_seq #(.PIPE_STAGES(2), .EN_SHA256(1'b1)) u_p2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    assign o_busy[0]  = bus1.busy;
    assign o_valid[0] = bus1.k_valid;
    assign o_last[0]  = bus1.k_last;
    assign o_done[0]  = bus1.done;
    assign o_k[0]     = bus1.k_out;
    assign o_idx[0]   = bus1.round_idx;
    assign o_busy[1]  = bus2.busy;
    assign o_valid[1] = bus2.k_valid;
    assign o_last[1]  = bus2.k_last;
    assign o_done[1]  = bus2.done;
    assign o_k[1]     = bus2.k_out;
    assign o_idx[1]   = bus2.round_idx;

    function automatic logic [63:0] exp_k(input bit m, input int t);
        logic [63:0] v;
        v = k_tab[t];
        return m ? {32'h0, v[63:32]} : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({o_busy[d], o_valid[d], o_last[d], o_done[d]} !== 4'b0000)
                $display("[TB] FAIL reset_flags dut%0d: got %b expected 0000", d,
                         {o_busy[d], o_valid[d], o_last[d], o_done[d]});
            else passes++;
            checks++;
            if (o_k[d] !== 64'h0) $display("[TB] FAIL reset_k dut%0d: got %h expected 0", d, o_k[d]);
            else passes++;
            checks++;
            if (o_idx[d] !== 7'd0) $display("[TB] FAIL reset_idx dut%0d: got %0d expected 0", d, o_idx[d]);
            else passes++;
        end
    endtask

    // Start at edge c; instance d shows round t at sample c+(d+1)+t; done at c+(d+1)+N.
    task automatic test_full_run(input bit m);
        int n, p, t;
        bit ev;
        n = m ? 64 : 80;
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= n + 4; k++) begin
            for (int d = 0; d < 2; d++) begin
                p  = d + 1;
                t  = k - p;
                ev = (k >= p) && (k < p + n);
                checks++;
                if (o_valid[d] !== ev) $display("[TB] FAIL run_valid dut%0d k=%0d: got %b expected %b", d, k, o_valid[d], ev);
                else passes++;
                if (ev) begin
                    checks++;
                    if (o_idx[d] !== 7'(t)) $display("[TB] FAIL run_idx dut%0d: got %0d expected %0d", d, o_idx[d], t);
                    else passes++;
                    checks++;
                    if (o_k[d] !== exp_k(m, t)) $display("[TB] FAIL run_k dut%0d t=%0d: got %h expected %h", d, t, o_k[d], exp_k(m, t));
                    else passes++;
                    checks++;
                    if (o_last[d] !== (t == n - 1)) $display("[TB] FAIL run_last dut%0d t=%0d: got %b", d, t, o_last[d]);
                    else passes++;
                end
                checks++;
                if (o_done[d] !== (k == p + n)) $display("[TB] FAIL run_done dut%0d k=%0d: got %b expected %b", d, k, o_done[d], (k == p + n));
                else passes++;
                checks++;
                if (o_busy[d] !== (k < p + n)) $display("[TB] FAIL run_busy dut%0d k=%0d: got %b expected %b", d, k, o_busy[d], (k < p + n));
                else passes++;
            end
            if (k == 1) begin
                checks++;
                if (o_k[0] !== (m ? 64'h00000000428a2f98 : 64'h428a2f98d728ae22))
                    $display("[TB] FAIL first_const: got %h", o_k[0]);
                else passes++;
            end
            if (k == n) begin
                checks++;
                if (o_k[0] !== (m ? 64'h00000000c67178f2 : 64'h6c44198c4a475817) || o_last[0] !== 1'b1)
                    $display("[TB] FAIL last_const: got %h last=%b", o_k[0], o_last[0]);
                else passes++;
            end
            // Mode and start wiggle mid-run; both must be ignored while busy.
            mode  = 1'($urandom_range(0, 1));
            start = (k < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        start = 1'b0;
        mode  = 1'b0;
    endtask

    task automatic test_stall(input bit m);
        int  n;
        int  nxt [2];
        int  dones [2];
        bit  cons_last [2];
        int  forced;
        bit  forced_used, in_forced;
        n = m ? 64 : 80;
        nxt = '{0, 0};
        dones = '{0, 0};
        cons_last = '{1'b0, 1'b0};
        forced = 0;
        forced_used = 1'b0;
        mode  = m;
        stall = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (o_done[d] !== cons_last[d]) $display("[TB] FAIL stall_done dut%0d cyc=%0d: got %b expected %b", d, cyc, o_done[d], cons_last[d]);
                else passes++;
                if (o_done[d] === 1'b1) dones[d]++;
                if (nxt[d] > 0 && nxt[d] < n) begin
                    checks++;
                    if (o_valid[d] !== 1'b1) $display("[TB] FAIL stall_gap dut%0d next=%0d: got %b expected 1", d, nxt[d], o_valid[d]);
                    else passes++;
                end else if (nxt[d] == n) begin
                    checks++;
                    if (o_valid[d] !== 1'b0) $display("[TB] FAIL stall_extra dut%0d: got %b expected 0", d, o_valid[d]);
                    else passes++;
                end
                if (o_valid[d] === 1'b1 && nxt[d] < n) begin
                    checks++;
                    if (o_idx[d] !== 7'(nxt[d]) || o_k[d] !== exp_k(m, nxt[d]) || o_last[d] !== (nxt[d] == n - 1))
                        $display("[TB] FAIL stall_beat dut%0d: got idx=%0d k=%h last=%b expected idx=%0d k=%h",
                                 d, o_idx[d], o_k[d], o_last[d], nxt[d], exp_k(m, nxt[d]));
                    else passes++;
                end
            end
            in_forced = 1'b0;
            if (forced > 0) begin
                stall = 1'b1;
                forced--;
                in_forced = 1'b1;
            end else if (!forced_used && o_valid[0] === 1'b1 && o_idx[0] == 7'd10) begin
                stall = 1'b1;
                forced = 2;
                forced_used = 1'b1;
                in_forced = 1'b1;
            end else begin
                stall = ($urandom_range(0, 3) == 0);
            end
            if (in_forced) begin
                checks++;
                if (o_idx[0] !== 7'd10 || o_k[0] !== (m ? 64'h00000000243185be : 64'h243185be4ee4b28c))
                    $display("[TB] FAIL stall_hold: got idx=%0d k=%h expected idx=10", o_idx[0], o_k[0]);
                else passes++;
            end
            for (int d = 0; d < 2; d++) begin
                cons_last[d] = 1'b0;
                if (o_valid[d] === 1'b1 && !stall && nxt[d] < n) begin
                    cons_last[d] = (nxt[d] == n - 1);
                    nxt[d]++;
                end
            end
            if (nxt[0] == n && nxt[1] == n && dones[0] > 0 && dones[1] > 0) break;
            tick();
        end
        stall = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (nxt[d] != n || dones[d] != 1)
                $display("[TB] FAIL stall_complete dut%0d: got beats=%0d dones=%0d expected %0d/1", d, nxt[d], dones[d], n);
            else passes++;
        end
        tick();
    endtask

    task automatic test_abort();
        int  cyc;
        bit  found, m;
        found = 1'b0;
        cyc = 0;
        mode  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (o_valid[0] === 1'b1 && o_idx[0] == 7'd40) begin
                found = 1'b1;
                cyc = c;
                break;
            end
            tick();
        end
        checks++;
        if (!found || cyc != 41 || o_k[0] !== 64'ha2bfe8a14cf10364)
            $display("[TB] FAIL abort_reach: got found=%b cyc=%0d k=%h expected cyc=41", found, cyc, o_k[0]);
        else passes++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int c = 0; c < 5; c++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({o_valid[d], o_busy[d], o_done[d]} !== 3'b000)
                    $display("[TB] FAIL abort_quiet dut%0d c=%0d: got v/b/d=%b expected 000", d, c, {o_valid[d], o_busy[d], o_done[d]});
                else passes++;
            end
            tick();
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({o_valid[d], o_busy[d]} !== 2'b00)
                    $display("[TB] FAIL abort_start dut%0d: got v/b=%b expected 00", d, {o_valid[d], o_busy[d]});
                else passes++;
            end
            tick();
        end
        m = 1'($urandom_range(0, 1));
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (o_valid[d] !== (k >= d + 1)) $display("[TB] FAIL restart_valid dut%0d k=%0d: got %b", d, k, o_valid[d]);
                else passes++;
                if (k >= d + 1) begin
                    checks++;
                    if (o_idx[d] !== 7'(k - d - 1) || o_k[d] !== exp_k(m, k - d - 1))
                        $display("[TB] FAIL restart_beat dut%0d: got idx=%0d k=%h expected idx=%0d k=%h",
                                 d, o_idx[d], o_k[d], k - d - 1, exp_k(m, k - d - 1));
                    else passes++;
                end
            end
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit found;
        found = 1'b0;
        cyc = 0;
        mode  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (o_valid[0] === 1'b1 && o_idx[0] == 7'd20) begin
                found = 1'b1;
                cyc = c;
                break;
            end
            start = (o_valid[0] === 1'b1 && o_idx[0] == 7'd5);
            if (start) mode = 1'b1;
            tick();
        end
        start = 1'b0;
        checks++;
        if (!found || cyc != 21 || o_k[0] !== 64'h2de92c6f592b0275)
            $display("[TB] FAIL busy_start_ignored: got found=%b cyc=%0d k=%h expected cyc=21 k=2de92c6f592b0275", found, cyc, o_k[0]);
        else passes++;
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({o_busy[d], o_valid[d], o_last[d], o_done[d]} !== 4'b0000 || o_k[d] !== 64'h0 || o_idx[d] !== 7'd0)
                $display("[TB] FAIL async_reset dut%0d: got flags=%b k=%h idx=%0d expected all 0", d,
                         {o_busy[d], o_valid[d], o_last[d], o_done[d]}, o_k[d], o_idx[d]);
            else passes++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        mode  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int d = 0; d < 2; d++) begin
                if (k == d + 1) begin
                    checks++;
                    if (o_valid[d] !== 1'b1 || o_idx[d] !== 7'd0 || o_k[d] !== 64'h00000000428a2f98)
                        $display("[TB] FAIL post_reset_first dut%0d: got v=%b idx=%0d k=%h expected 1/0/00000000428a2f98",
                                 d, o_valid[d], o_idx[d], o_k[d]);
                    else passes++;
                end
            end
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        k_tab = '{
            64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
            64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
            64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
            64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
            64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
            64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
            64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
            64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
            64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
            64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
            64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
            64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
            64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
            64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
            64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
            64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
            64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
            64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
            64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
            64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
        };
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        stall = 1'b0;
        abort = 1'b0;
        #2;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_full_run(1'b0);
        test_full_run(1'b1);
        test_stall(1'b0);
        test_stall(1'($urandom_range(0, 1)));
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
